// File: rtl/dispatch_queue.sv
// dispatch_queue: circular FIFO of {select, data} requests feeding a demux stage.
// Outputs read the head entry combinationally from registered storage and are
// forced to zero while the queue is empty, so the downstream demux idles at zero.
module dispatch_queue #(
   parameter int CTRL       = 2,
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CTRL-1:0]            in_ctrl,
   input  logic [DATA_WIDTH-1:0]      in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CTRL-1:0]            out_ctrl,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = CTRL + DATA_WIDTH;

   localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

   logic [EW-1:0]   mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;

   logic            in_ready_s;
   logic            out_valid_s;
   logic            push_s;
   logic            pop_s;
   logic [EW-1:0]   head_s;

   // Handshake qualifiers: both depend only on registered occupancy.
   always_comb begin
      in_ready_s  = (count_r != CNT_FULL);
      out_valid_s = (count_r != CNT_ZERO);
      push_s      = in_valid & in_ready_s;
      pop_s       = out_valid_s & out_ready;
      head_s      = mem_r[rd_ptr_r];
   end

   // Entry storage: written on accepted push; never cleared (flush only moves pointers).
   always_ff @(posedge clk) begin
      if (push_s && !flush) begin
         mem_r[wr_ptr_r] <= {in_ctrl, in_data};
      end
   end

   // Pointer and occupancy state; flush overrides any concurrent push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else if (flush) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Output drive: head entry when valid, all-zero when empty.
   always_comb begin
      in_ready  = in_ready_s;
      out_valid = out_valid_s;
      count     = count_r;
      if (out_valid_s) begin
         out_ctrl = head_s[EW-1:DATA_WIDTH];
         out_data = head_s[DATA_WIDTH-1:0];
      end else begin
         out_ctrl = '0;
         out_data = '0;
      end
   end

endmodule
